rom_load_ctrl: RTL and testbench
================================

Name: rom_load_ctrl

Overview:
- Sits between hps_io's ioctl download stream and the core's ROM-write / reset inputs, on the clk_sys domain.
- Registers and range-checks the download stream and forwards it as dn_addr/dn_data/dn_wr.
- Holds the core in reset during a download, and for a fixed stretch after download or a user reset.
- Counts bytes and keeps a 16-bit additive checksum for load verification.

Parameters:
- LAST_ADDR, 16'hFFFF: highest accepted download address; writes above it are dropped.
- HOLD_CYCLES, 1024: clk_sys cycles core_reset stays asserted after the download ends or sw_reset drops; must be >= 1.
- CNT_W, 11: width of the hold counter; must satisfy 2^CNT_W > HOLD_CYCLES.

Ports:
- clk_sys, in, 1: system clock.
- reset, in, 1: asynchronous, active-high reset.
- ioctl_download, in, 1: download session active.
- ioctl_wr, in, 1: one-cycle write strobe.
- ioctl_addr, in, 25: byte address.
- ioctl_dout, in, 8: byte data.
- sw_reset, in, 1: level; menu or button reset request.
- dn_addr, out, 16: registered write address to the core.
- dn_data, out, 8: registered write data.
- dn_wr, out, 1: one-cycle write strobe to the core.
- core_reset, out, 1: reset to the core.
- load_done, out, 1: high once a download has completed; cleared when a new one starts.
- overflow, out, 1: sticky; an in-session write hit an address > LAST_ADDR.
- byte_count, out, 17: accepted writes in the current or last session; saturates at 17'h1FFFF.
- checksum, out, 16: mod-2^16 sum of accepted bytes.

Behaviour:
Reset (async assert) values:
- state = HOLD, hold counter = 0, core_reset = 1.
- dn_addr = 0, dn_data = 0, dn_wr = 0.
- load_done = 0, overflow = 0, byte_count = 0, checksum = 0.

State IDLE_RUN:
- core_reset = 0.
- ioctl_download rising (registered edge detect) -> LOAD; clear byte_count, checksum, overflow and load_done in the same cycle.
- sw_reset = 1 without a download -> HOLD; counter = 0.

State LOAD:
- core_reset = 1.
- Accept rule: an ioctl_wr is accepted when ioctl_download = 1, ioctl_addr[24:16] = 0 and ioctl_addr[15:0] <= LAST_ADDR.
- On an accepted write, the next cycle shows dn_wr = 1, dn_addr = ioctl_addr[15:0] and dn_data = ioctl_dout. Latency is exactly 1 cycle, and dn_wr lasts exactly 1 cycle per strobe.
- On the same edge: checksum += ioctl_dout (wraps); byte_count += 1 (holds at max).
- An ioctl_wr with ioctl_download = 1 that fails the accept rule sets overflow; no dn_wr is issued.
- ioctl_wr while ioctl_download = 0 is ignored in every state.
- Back-to-back strobes on consecutive cycles are all forwarded.
- ioctl_download falling -> HOLD; counter = 0; load_done = 1 on entry.
- sw_reset during LOAD has no effect; the download already holds reset.

State HOLD:
- core_reset = 1.
- The counter increments only while sw_reset = 0 and ioctl_download = 0. sw_reset = 1 clears it.
- Counter reaching HOLD_CYCLES-1 -> IDLE_RUN next edge. core_reset is therefore 1 for exactly HOLD_CYCLES cycles after the later of download end and sw_reset release.
- A download rising edge while in HOLD -> LOAD, with the same clears as from IDLE_RUN.

General:
- dn_wr is never asserted outside LOAD, except for the single trailing cycle of a write accepted on the last LOAD cycle.
- core_reset is a registered output: no glitches, and no combinational path from ioctl inputs.
- An async reset mid-download aborts the session: no further dn_wr until a new rising edge of ioctl_download is seen. If the reset releases with ioctl_download already high, the controller waits in HOLD with the counter frozen and does not enter LOAD.

Test Plan:
- Power-up: hold reset 5 cycles, release with all inputs 0 -> core_reset = 1 for 1024 cycles, then 0; load_done = 0.
- Download of 4 bytes A5,5A,01,FF at addresses 0..3, one every 3 cycles -> 4 dn_wr pulses, each 1 cycle after its ioctl_wr with matching addr/data; byte_count = 4, checksum = 16'h01FF; load_done = 1 on the download's fall; core_reset released 1024 cycles later.
- Back-to-back strobes at 16'hFFFE, 16'hFFFF, 25'h10000 -> two dn_wr pulses on consecutive cycles, third dropped; overflow = 1; byte_count = 2.
- sw_reset high for 50 cycles while in IDLE_RUN -> core_reset = 1 throughout and for 1024 cycles after sw_reset falls; dn_wr stays 0.
- Async reset pulse after the 2nd of 4 writes -> dn_wr stays 0 even though ioctl_download remains 1 and strobes continue; no LOAD entry until ioctl_download falls and rises again; byte_count = 0.
- Second download after a completed one -> byte_count, checksum and overflow clear on the rising edge; load_done drops to 0 and rises again at the end.

Source files
------------

// File: rtl/rom_load_ctrl_if.sv
// ----------------------------------------------------------------------------
// rom_load_ctrl_if
//
// Groups the hps_io download stream (ioctl_*) and the forwarded ROM-write
// stream (dn_*) that rom_load_ctrl sits between.
//
// Handshake: both streams are strobe-only, with no ready/backpressure. A
// write happens in every cycle where its *_wr strobe is high. Address and
// data are valid only in those cycles. The consumer must accept a write
// on any cycle, including consecutive cycles.
//
// Modports:
//   master : download source / ROM sink (drives ioctl_*, observes dn_*)
//   slave  : rom_load_ctrl (observes ioctl_*, drives dn_*)
// ----------------------------------------------------------------------------
interface rom_load_ctrl_if;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;

    logic [15:0] dn_addr;
    logic [7:0]  dn_data;
    logic        dn_wr;

    modport master (
        output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
        input  dn_addr, dn_data, dn_wr
    );

    modport slave (
        input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
        output dn_addr, dn_data, dn_wr
    );
endinterface

// File: rtl/rom_load_ctrl.sv
// ----------------------------------------------------------------------------
// rom_load_ctrl
//
// Sits between the ioctl download stream and the core's ROM-write and reset
// inputs. It registers the download stream and range-checks it, then
// forwards it as dn_*. It holds the core in reset during a download, and for
// HOLD_CYCLES cycles after the download or a user reset. It also counts the
// accepted bytes and keeps a 16-bit additive checksum of them.
//
// Ports:
//   clk_sys    : system clock
//   reset      : asynchronous, active-high reset
//   bus        : ioctl_* in / dn_* out (rom_load_ctrl_if.slave)
//   sw_reset   : level reset request from menu/button
//   core_reset : registered reset to the core
//   load_done  : a download has completed (cleared when a new one starts)
//   overflow   : sticky, an in-session write hit an out-of-range address
//   byte_count : accepted writes this/last session, saturating
//   checksum   : mod-2^16 sum of accepted bytes
//   dbg_state  : current FSM state (HOLD=0, IDLE_RUN=1, LOAD=2)
// ----------------------------------------------------------------------------
module rom_load_ctrl #(
    parameter logic [15:0] LAST_ADDR   = 16'hFFFF,
    parameter int          HOLD_CYCLES = 1024,
    parameter int          CNT_W       = 11
) (
    input  logic                 clk_sys,
    input  logic                 reset,
    rom_load_ctrl_if.slave       bus,
    input  logic                 sw_reset,
    output logic                 core_reset,
    output logic                 load_done,
    output logic                 overflow,
    output logic [16:0]          byte_count,
    output logic [15:0]          checksum,
    output logic [1:0]           dbg_state
);

    typedef enum logic [1:0] {
        HOLD     = 2'd0,
        IDLE_RUN = 2'd1,
        LOAD     = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    // One bit wider so the range check stays meaningful when LAST_ADDR = 16'hFFFF.
    localparam logic [16:0]      LAST_EXT  = {1'b0, LAST_ADDR};

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dl_q;
    logic             core_reset_q;
    logic [15:0]      dn_addr_q, dn_addr_d;
    logic [7:0]       dn_data_q, dn_data_d;
    logic             dn_wr_q, dn_wr_d;
    logic             load_done_q, load_done_d;
    logic             overflow_q, overflow_d;
    logic [16:0]      byte_count_q, byte_count_d;
    logic [15:0]      checksum_q, checksum_d;

    logic dl_rise;
    logic addr_ok;
    logic take_write;
    logic clear_stats;

    // dl_q resets to 1. If the reset releases while ioctl_download is
    // already high, no rising edge is seen, so the aborted session cannot
    // resume until the download drops and rises again.
    assign dl_rise = bus.ioctl_download & ~dl_q;
    assign addr_ok = (bus.ioctl_addr[24:16] == 9'd0) &&
                     ({1'b0, bus.ioctl_addr[15:0]} <= LAST_EXT);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        dn_addr_d    = dn_addr_q;
        dn_data_d    = dn_data_q;
        dn_wr_d      = 1'b0;
        load_done_d  = load_done_q;
        overflow_d   = overflow_q;
        byte_count_d = byte_count_q;
        checksum_d   = checksum_q;
        take_write   = 1'b0;
        clear_stats  = 1'b0;

        case (state_q)
            HOLD: begin
                if (dl_rise) begin
                    state_d     = LOAD;
                    clear_stats = 1'b1;
                end else if (sw_reset) begin
                    cnt_d = '0;
                end else if (!bus.ioctl_download) begin
                    if (cnt_q == HOLD_LAST) begin
                        state_d = IDLE_RUN;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                // ioctl_download high without an edge: counter stays frozen.
            end
            IDLE_RUN: begin
                if (dl_rise) begin
                    state_d     = LOAD;
                    clear_stats = 1'b1;
                end else if (sw_reset) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end
            end
            LOAD: begin
                if (!bus.ioctl_download) begin
                    state_d     = HOLD;
                    cnt_d       = '0;
                    load_done_d = 1'b1;
                end else begin
                    take_write = 1'b1;
                end
            end
            default: begin
                state_d = HOLD;
                cnt_d   = '0;
            end
        endcase

        // A strobe in the same cycle as the rising edge counts toward the
        // new session, after the stats are cleared.
        if (clear_stats) begin
            load_done_d  = 1'b0;
            overflow_d   = 1'b0;
            byte_count_d = '0;
            checksum_d   = '0;
            take_write   = 1'b1;
        end

        if (take_write && bus.ioctl_wr) begin
            if (addr_ok) begin
                dn_wr_d    = 1'b1;
                dn_addr_d  = bus.ioctl_addr[15:0];
                dn_data_d  = bus.ioctl_dout;
                checksum_d = checksum_d + {8'h00, bus.ioctl_dout};
                if (byte_count_d != 17'h1FFFF) begin
                    byte_count_d = byte_count_d + 17'd1;
                end
            end else begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q      <= HOLD;
            cnt_q        <= '0;
            dl_q         <= 1'b1;
            core_reset_q <= 1'b1;
            dn_addr_q    <= '0;
            dn_data_q    <= '0;
            dn_wr_q      <= 1'b0;
            load_done_q  <= 1'b0;
            overflow_q   <= 1'b0;
            byte_count_q <= '0;
            checksum_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            dl_q         <= bus.ioctl_download;
            core_reset_q <= (state_d != IDLE_RUN);
            dn_addr_q    <= dn_addr_d;
            dn_data_q    <= dn_data_d;
            dn_wr_q      <= dn_wr_d;
            load_done_q  <= load_done_d;
            overflow_q   <= overflow_d;
            byte_count_q <= byte_count_d;
            checksum_q   <= checksum_d;
        end
    end

    assign bus.dn_addr = dn_addr_q;
    assign bus.dn_data = dn_data_q;
    assign bus.dn_wr   = dn_wr_q;
    assign core_reset  = core_reset_q;
    assign load_done   = load_done_q;
    assign overflow    = overflow_q;
    assign byte_count  = byte_count_q;
    assign checksum    = checksum_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_rom_load_ctrl.sv
// ----------------------------------------------------------------------------
// tb_rom_load_ctrl
//
// Directed testbench for rom_load_ctrl. Inputs change 1 ns after a rising
// edge and outputs are read at that point. dn_wr pulses are captured on
// falling edges as {cycle, addr, data}.
// ----------------------------------------------------------------------------
module tb_rom_load_ctrl;

    localparam int         HOLD     = 1024;
    localparam logic [1:0] S_HOLD   = 2'd0;
    localparam logic [1:0] S_IDLE   = 2'd1;
    localparam logic [1:0] S_LOAD   = 2'd2;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        sw_reset;
    logic        core_reset;
    logic        load_done;
    logic        overflow;
    logic [16:0] byte_count;
    logic [15:0] checksum;
    logic [1:0]  dbg_state;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    logic [55:0] exp_q[$];
    logic [55:0] obs_q[$];

    rom_load_ctrl_if bus ();

    rom_load_ctrl #(
        .LAST_ADDR  (16'hFFFF),
        .HOLD_CYCLES(HOLD),
        .CNT_W      (11)
    ) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .bus       (bus.slave),
        .sw_reset  (sw_reset),
        .core_reset(core_reset),
        .load_done (load_done),
        .overflow  (overflow),
        .byte_count(byte_count),
        .checksum  (checksum),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / cycle counter / dn_wr capture ----------------
    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) cyc <= cyc + 1;

    always @(negedge clk_sys) begin
        if (bus.dn_wr === 1'b1) obs_q.push_back({32'(cyc), bus.dn_addr, bus.dn_data});
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    // One-cycle strobe; optionally records the expected forwarded write.
    task automatic ioctl_write(input logic [24:0] a, input logic [7:0] d, input logic expect_fwd);
        bus.ioctl_wr   = 1'b1;
        bus.ioctl_addr = a;
        bus.ioctl_dout = d;
        if (expect_fwd) exp_q.push_back({32'(cyc + 1), a[15:0], d});
        step(1);
        bus.ioctl_wr = 1'b0;
    endtask

    // Counts sampled cycles with core_reset high, starting now, bounded.
    task automatic count_reset(output int n);
        n = 0;
        while (core_reset === 1'b1 && n < 3000) begin
            n++;
            step(1);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        int n;
        tests_run++; if (core_reset !== 1'b1) begin tests_failed++; $display("FAIL rst_core_reset got=%b exp=1", core_reset); end
        tests_run++; if (bus.dn_wr !== 1'b0 || bus.dn_addr !== 16'h0 || bus.dn_data !== 8'h0) begin tests_failed++; $display("FAIL rst_dn got wr=%b a=%h d=%h exp 0/0/0", bus.dn_wr, bus.dn_addr, bus.dn_data); end
        tests_run++; if (load_done !== 1'b0 || overflow !== 1'b0) begin tests_failed++; $display("FAIL rst_flags got ld=%b ov=%b exp 0/0", load_done, overflow); end
        tests_run++; if (byte_count !== 17'h0 || checksum !== 16'h0) begin tests_failed++; $display("FAIL rst_stats got bc=%h cs=%h exp 0/0", byte_count, checksum); end
        tests_run++; if (dbg_state !== S_HOLD) begin tests_failed++; $display("FAIL rst_state got=%0d exp=%0d", dbg_state, S_HOLD); end
        reset = 1'b0;
        count_reset(n);
        tests_run++; if (n !== HOLD) begin tests_failed++; $display("FAIL powerup_hold got=%0d exp=%0d", n, HOLD); end
        tests_run++; if (dbg_state !== S_IDLE || load_done !== 1'b0) begin tests_failed++; $display("FAIL powerup_idle got st=%0d ld=%b exp st=1 ld=0", dbg_state, load_done); end
    endtask

    task automatic test_download;
        int n;
        logic [7:0] bytes[4];
        bytes = '{8'hA5, 8'h5A, 8'h01, 8'hFF};
        exp_q.delete(); obs_q.delete();
        bus.ioctl_download = 1'b1;
        step(1);
        tests_run++; if (dbg_state !== S_LOAD || core_reset !== 1'b1) begin tests_failed++; $display("FAIL dl_enter got st=%0d cr=%b exp st=2 cr=1", dbg_state, core_reset); end
        for (int i = 0; i < 4; i++) begin
            ioctl_write(25'(i), bytes[i], 1'b1);
            step(2);
        end
        tests_run++; if (byte_count !== 17'd4) begin tests_failed++; $display("FAIL dl_count got=%0d exp=4", byte_count); end
        tests_run++; if (checksum !== 16'h01FF) begin tests_failed++; $display("FAIL dl_checksum got=%h exp=01ff", checksum); end
        tests_run++; if (load_done !== 1'b0) begin tests_failed++; $display("FAIL dl_done_early got=%b exp=0", load_done); end
        bus.ioctl_download = 1'b0;
        step(1);
        tests_run++; if (load_done !== 1'b1 || dbg_state !== S_HOLD) begin tests_failed++; $display("FAIL dl_done got ld=%b st=%0d exp ld=1 st=0", load_done, dbg_state); end
        count_reset(n);
        tests_run++; if (n !== HOLD) begin tests_failed++; $display("FAIL dl_hold got=%0d exp=%0d", n, HOLD); end
        tests_run++; if (obs_q.size() !== exp_q.size()) begin tests_failed++; $display("FAIL dl_pulses got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            tests_run++; if (obs_q[i] !== exp_q[i]) begin tests_failed++; $display("FAIL dl_write%0d got=%h exp=%h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_back_to_back;
        int n;
        exp_q.delete(); obs_q.delete();
        bus.ioctl_download = 1'b1;
        step(1);
        ioctl_write(25'h0FFFE, 8'h11, 1'b1);
        ioctl_write(25'h0FFFF, 8'h22, 1'b1);
        ioctl_write(25'h10000, 8'h44, 1'b0);
        step(2);
        tests_run++; if (overflow !== 1'b1) begin tests_failed++; $display("FAIL b2b_overflow got=%b exp=1", overflow); end
        tests_run++; if (byte_count !== 17'd2) begin tests_failed++; $display("FAIL b2b_count got=%0d exp=2", byte_count); end
        tests_run++; if (checksum !== 16'h0033) begin tests_failed++; $display("FAIL b2b_checksum got=%h exp=0033", checksum); end
        tests_run++; if (bus.dn_addr !== 16'hFFFF || bus.dn_data !== 8'h22) begin tests_failed++; $display("FAIL b2b_last got a=%h d=%h exp ffff/22", bus.dn_addr, bus.dn_data); end
        tests_run++; if (obs_q.size() !== 2) begin tests_failed++; $display("FAIL b2b_pulses got=%0d exp=2", obs_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            tests_run++; if (obs_q[i] !== exp_q[i]) begin tests_failed++; $display("FAIL b2b_write%0d got=%h exp=%h", i, obs_q[i], exp_q[i]); end
        end
        bus.ioctl_download = 1'b0;
        step(1);
        count_reset(n);
        tests_run++; if (n !== HOLD || overflow !== 1'b1) begin tests_failed++; $display("FAIL b2b_after got hold=%0d ov=%b exp %0d/1", n, overflow, HOLD); end
    endtask

    task automatic test_second_download;
        int n;
        exp_q.delete(); obs_q.delete();
        bus.ioctl_download = 1'b1;
        step(1);
        tests_run++; if (load_done !== 1'b0 || overflow !== 1'b0) begin tests_failed++; $display("FAIL dl2_flags got ld=%b ov=%b exp 0/0", load_done, overflow); end
        tests_run++; if (byte_count !== 17'd0 || checksum !== 16'h0) begin tests_failed++; $display("FAIL dl2_clear got bc=%0d cs=%h exp 0/0000", byte_count, checksum); end
        ioctl_write(25'h01234, 8'h7E, 1'b1);
        step(1);
        tests_run++; if (byte_count !== 17'd1 || checksum !== 16'h007E) begin tests_failed++; $display("FAIL dl2_stats got bc=%0d cs=%h exp 1/007e", byte_count, checksum); end
        bus.ioctl_download = 1'b0;
        step(1);
        tests_run++; if (load_done !== 1'b1) begin tests_failed++; $display("FAIL dl2_done got=%b exp=1", load_done); end
        count_reset(n);
        tests_run++; if (n !== HOLD) begin tests_failed++; $display("FAIL dl2_hold got=%0d exp=%0d", n, HOLD); end
        tests_run++; if (obs_q.size() !== 1 || (obs_q.size() == 1 && obs_q[0] !== exp_q[0])) begin tests_failed++; $display("FAIL dl2_write got n=%0d exp n=1 %h", obs_q.size(), exp_q[0]); end
    endtask

    task automatic test_sw_reset;
        int n;
        int low_seen;
        exp_q.delete(); obs_q.delete();
        low_seen = 0;
        sw_reset = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (i == 20) ioctl_write(25'h00010, 8'h99, 1'b0);
            else step(1);
            if (core_reset !== 1'b1) low_seen++;
        end
        tests_run++; if (low_seen !== 0) begin tests_failed++; $display("FAIL sw_during got low_cycles=%0d exp=0", low_seen); end
        sw_reset = 1'b0;
        count_reset(n);
        tests_run++; if (n !== HOLD) begin tests_failed++; $display("FAIL sw_hold got=%0d exp=%0d", n, HOLD); end
        tests_run++; if (obs_q.size() !== 0) begin tests_failed++; $display("FAIL sw_no_write got=%0d exp=0", obs_q.size()); end
    endtask

    task automatic test_async_abort;
        int n;
        exp_q.delete(); obs_q.delete();
        bus.ioctl_download = 1'b1;
        step(1);
        ioctl_write(25'h00000, 8'h10, 1'b1);
        step(2);
        ioctl_write(25'h00001, 8'h20, 1'b1);
        step(1);
        reset = 1'b1;
        #3;
        tests_run++; if (core_reset !== 1'b1 || byte_count !== 17'd0) begin tests_failed++; $display("FAIL abort_async got cr=%b bc=%0d exp 1/0", core_reset, byte_count); end
        step(2);
        reset = 1'b0;
        ioctl_write(25'h00002, 8'h30, 1'b0);
        step(2);
        ioctl_write(25'h00003, 8'h40, 1'b0);
        step(1100);
        tests_run++; if (dbg_state !== S_HOLD || core_reset !== 1'b1) begin tests_failed++; $display("FAIL abort_frozen got st=%0d cr=%b exp 0/1", dbg_state, core_reset); end
        tests_run++; if (byte_count !== 17'd0 || obs_q.size() !== 2) begin tests_failed++; $display("FAIL abort_writes got bc=%0d pulses=%0d exp 0/2", byte_count, obs_q.size()); end
        bus.ioctl_download = 1'b0;
        step(1);
        bus.ioctl_download = 1'b1;
        step(1);
        tests_run++; if (dbg_state !== S_LOAD) begin tests_failed++; $display("FAIL abort_reenter got st=%0d exp=2", dbg_state); end
        ioctl_write(25'h00005, 8'h55, 1'b1);
        step(1);
        bus.ioctl_download = 1'b0;
        step(1);
        count_reset(n);
        tests_run++; if (n !== HOLD || byte_count !== 17'd1) begin tests_failed++; $display("FAIL abort_resume got hold=%0d bc=%0d exp %0d/1", n, byte_count, HOLD); end
        tests_run++; if (obs_q.size() !== exp_q.size()) begin tests_failed++; $display("FAIL abort_pulses got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            tests_run++; if (obs_q[i] !== exp_q[i]) begin tests_failed++; $display("FAIL abort_write%0d got=%h exp=%h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        reset              = 1'b1;
        sw_reset           = 1'b0;
        bus.ioctl_download = 1'b0;
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_addr     = '0;
        bus.ioctl_dout     = '0;
        step(5);
        test_reset();
        step(3);
        test_download();
        step(3);
        test_back_to_back();
        step(3);
        test_second_download();
        step(3);
        test_sw_reset();
        step(3);
        test_async_abort();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
